// File: rtl/dbg_pkg.sv
// Shared constants, status codes and FSM state type for the debug command engine.
package dbg_pkg;

    localparam logic [3:0] OP_MAGIC = 4'hA;

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_TOUT  = 8'h01;
    localparam logic [7:0] ST_BADOP = 8'hEE;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StAddr,
        StWdata,
        StXfer,
        StRtx,
        StStatus,
        StErr
    } dbg_state_e;

    // Valid opcodes are 0xA0..0xA3: magic nibble, bits [3:2] clear.
    function automatic logic op_valid(input logic [7:0] op);
        return (op[7:4] == OP_MAGIC) && (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/dbg_apb_xfer.sv
// Single APB access with optional bus timeout. The access is active for as long as
// start is held; done pulses in the completing cycle (pready or timeout).
module dbg_apb_xfer #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] rdata,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_hit;

    assign penable = start;
    assign pwrite  = write;
    assign paddr   = addr;
    assign pwdata  = wdata;

    // cnt_q == n means penable has already been high for n cycles of this access
    assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign done    = penable && (pready || tmo_hit);
    assign timeout = penable && !pready && tmo_hit;
    assign rdata   = timeout ? '0 : prdata;

    // Count active cycles; restart after every completed or idle cycle.
    always_comb begin
        cnt_d = '0;
        if (penable && !done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dbg_cmd_burst.sv
// Byte-stream debug command engine: parses OP/LEN/ADDR/WDATA from the RX FIFO, runs
// single or burst APB accesses and returns read data plus a status byte on the TX FIFO.
module dbg_cmd_burst
    import dbg_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fifo_empty,
    output logic              o_fifo_read,
    input  logic [7:0]        i_fifo_rdata,
    input  logic              i_fifo_full,
    output logic              o_fifo_write,
    output logic [7:0]        o_fifo_wdata,
    output logic              o_penable,
    output logic              o_pwrite,
    output logic [ADDR_W-1:0] o_paddr,
    output logic [DATA_W-1:0] o_pwdata,
    input  logic              i_pready,
    input  logic [DATA_W-1:0] i_prdata,
    output logic              o_busy
);

    localparam int unsigned ABYTES = ADDR_W / 8;
    localparam int unsigned DBYTES = DATA_W / 8;

    dbg_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic              incr_q, incr_d;
    logic              tout_q, tout_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_q, beat_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              beat_end;

    logic              xfer_start, xfer_done, xfer_tout;
    logic [DATA_W-1:0] xfer_rdata;

    // Once a burst has timed out, remaining beats bypass the bus entirely.
    assign xfer_start = (state_q == StXfer) && !tout_q;
    assign o_busy     = (state_q != StIdle);

    dbg_apb_xfer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_xfer (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (xfer_start),
        .write   (write_q),
        .addr    (addr_q),
        .wdata   (wdata_q),
        .pready  (i_pready),
        .prdata  (i_prdata),
        .done    (xfer_done),
        .timeout (xfer_tout),
        .rdata   (xfer_rdata),
        .penable (o_penable),
        .pwrite  (o_pwrite),
        .paddr   (o_paddr),
        .pwdata  (o_pwdata)
    );

    // Command FSM: next state, shift registers, counters and FIFO handshakes.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        incr_d       = incr_q;
        tout_d       = tout_q;
        len_d        = len_q;
        beat_d       = beat_q;
        bcnt_d       = bcnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        o_fifo_read  = 1'b0;
        o_fifo_write = 1'b0;
        o_fifo_wdata = 8'h00;
        beat_end     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!i_fifo_empty) begin
                    o_fifo_read = 1'b1;
                    if (op_valid(i_fifo_rdata)) begin
                        write_d = i_fifo_rdata[0];
                        incr_d  = i_fifo_rdata[1];
                        state_d = StLen;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                if (!i_fifo_full) begin
                    o_fifo_write = 1'b1;
                    o_fifo_wdata = ST_BADOP;
                    state_d      = StIdle;
                end
            end
            StLen: begin
                if (!i_fifo_empty) begin
                    o_fifo_read = 1'b1;
                    len_d       = i_fifo_rdata;
                    beat_d      = '0;
                    bcnt_d      = '0;
                    state_d     = StAddr;
                end
            end
            StAddr: begin
                if (!i_fifo_empty) begin
                    o_fifo_read = 1'b1;
                    addr_d      = (addr_q << 8) | ADDR_W'(i_fifo_rdata);
                    if (bcnt_q == 4'(ABYTES - 1)) begin
                        bcnt_d  = '0;
                        state_d = write_q ? StWdata : StXfer;
                    end else begin
                        bcnt_d  = bcnt_q + 4'd1;
                    end
                end
            end
            StWdata: begin
                if (!i_fifo_empty) begin
                    o_fifo_read = 1'b1;
                    wdata_d     = (wdata_q << 8) | DATA_W'(i_fifo_rdata);
                    if (bcnt_q == 4'(DBYTES - 1)) begin
                        bcnt_d  = '0;
                        state_d = StXfer;
                    end else begin
                        bcnt_d  = bcnt_q + 4'd1;
                    end
                end
            end
            StXfer: begin
                if (tout_q || xfer_done) begin
                    if (xfer_tout) begin
                        tout_d = 1'b1;
                    end
                    if (write_q) begin
                        beat_end = 1'b1;
                    end else begin
                        rdata_d = tout_q ? '0 : xfer_rdata;
                        bcnt_d  = '0;
                        state_d = StRtx;
                    end
                end
            end
            StRtx: begin
                if (!i_fifo_full) begin
                    o_fifo_write = 1'b1;
                    o_fifo_wdata = rdata_q[DATA_W-1 -: 8];
                    rdata_d      = rdata_q << 8;
                    if (bcnt_q == 4'(DBYTES - 1)) begin
                        beat_end = 1'b1;
                    end else begin
                        bcnt_d   = bcnt_q + 4'd1;
                    end
                end
            end
            StStatus: begin
                if (!i_fifo_full) begin
                    o_fifo_write = 1'b1;
                    o_fifo_wdata = tout_q ? ST_TOUT : ST_OK;
                    tout_d       = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Advance to the next beat or finish the burst.
        if (beat_end) begin
            bcnt_d = '0;
            if (beat_q == len_q) begin
                state_d = StStatus;
            end else begin
                beat_d  = beat_q + 8'd1;
                addr_d  = addr_q + (incr_q ? ADDR_W'(DBYTES) : '0);
                state_d = write_q ? StWdata : StXfer;
            end
        end
    end

    // State and datapath registers; reset drops any partial command.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            incr_q  <= 1'b0;
            tout_q  <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            bcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            incr_q  <= incr_d;
            tout_q  <= tout_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            bcnt_q  <= bcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dbg_cmd_burst.sv
// Scoreboard bench for dbg_cmd_burst: expected TX bytes and APB accesses are queued as
// commands are sent and compared as the DUT produces them.
module tb_dbg_cmd_burst;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;
    localparam int unsigned OW = 5 + 8 + AW + DW;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } apb_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_fifo_empty;
    logic          o_fifo_read;
    logic [7:0]    i_fifo_rdata;
    logic          i_fifo_full;
    logic          o_fifo_write;
    logic [7:0]    o_fifo_wdata;
    logic          o_penable;
    logic          o_pwrite;
    logic [AW-1:0] o_paddr;
    logic [DW-1:0] o_pwdata;
    logic          i_pready;
    logic [DW-1:0] i_prdata;
    logic          o_busy;

    logic [7:0]    rx_q[$];
    logic [7:0]    tx_exp[$];
    apb_t          apb_exp[$];
    logic [DW-1:0] prd_q[$];

    int vectors = 0;
    int errors  = 0;
    int pen_cur = 0;
    int last_run = 0;
    int pen_runs = 0;

    dbg_cmd_burst #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_read  (o_fifo_read),
        .i_fifo_rdata (i_fifo_rdata),
        .i_fifo_full  (i_fifo_full),
        .o_fifo_write (o_fifo_write),
        .o_fifo_wdata (o_fifo_wdata),
        .o_penable    (o_penable),
        .o_pwrite     (o_pwrite),
        .o_paddr      (o_paddr),
        .o_pwdata     (o_pwdata),
        .i_pready     (i_pready),
        .i_prdata     (i_prdata),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic refresh();
        i_fifo_empty = (rx_q.size() == 0);
        i_fifo_rdata = i_fifo_empty ? 8'h00 : rx_q[0];
        i_prdata     = (prd_q.size() != 0) ? prd_q[0] : '0;
    endtask

    // One clock: sample at negedge, compare against the scoreboard, update inputs after posedge.
    task automatic tick();
        logic   rd;
        logic   rd_done;
        logic [7:0] eb;
        apb_t   ea;
        @(negedge i_clk);
        rd      = o_fifo_read;
        rd_done = 1'b0;
        if (o_fifo_read && i_fifo_empty) begin
            errors++;
            $display("FAIL rx_pop_on_empty: got read=1 with empty=1, need read=0");
        end
        if (o_fifo_write) begin
            vectors++;
            if (tx_exp.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got byte %02h, need no byte", o_fifo_wdata);
            end else begin
                eb = tx_exp.pop_front();
                if (o_fifo_wdata !== eb || i_fifo_full !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h (full=%b), need %02h (full=0)",
                             o_fifo_wdata, i_fifo_full, eb);
                end
            end
        end
        if (o_penable) begin
            pen_cur++;
            if (i_pready) begin
                vectors++;
                if (!o_pwrite) rd_done = 1'b1;
                if (apb_exp.size() == 0) begin
                    errors++;
                    $display("FAIL apb_unexpected: got w=%b a=%h", o_pwrite, o_paddr);
                end else begin
                    ea = apb_exp.pop_front();
                    if (o_pwrite !== ea.w || o_paddr !== ea.a || (ea.w && o_pwdata !== ea.d)) begin
                        errors++;
                        $display("FAIL apb_access: got w=%b a=%h d=%h, need w=%b a=%h d=%h",
                                 o_pwrite, o_paddr, o_pwdata, ea.w, ea.a, ea.d);
                    end
                end
            end
        end else if (pen_cur != 0) begin
            last_run = pen_cur;
            pen_cur  = 0;
            pen_runs++;
        end
        @(posedge i_clk);
        #1;
        if (rd && rx_q.size() != 0) void'(rx_q.pop_front());
        if (rd_done && prd_q.size() != 0) void'(prd_q.pop_front());
        refresh();
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] len, input logic [AW-1:0] a);
        rx_q.push_back(op);
        rx_q.push_back(len);
        for (int i = AW / 8 - 1; i >= 0; i--) rx_q.push_back(a[i*8 +: 8]);
        refresh();
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = DW / 8 - 1; i >= 0; i--) rx_q.push_back(w[i*8 +: 8]);
        refresh();
    endtask

    task automatic exp_word(input logic [DW-1:0] w);
        for (int i = DW / 8 - 1; i >= 0; i--) tx_exp.push_back(w[i*8 +: 8]);
    endtask

    task automatic exp_apb(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        apb_t e;
        e.w = w;
        e.a = a;
        e.d = d;
        apb_exp.push_back(e);
    endtask

    // Run until the command stream is consumed and the engine is idle, then drain-check.
    task automatic wait_idle(input string name);
        int n = 0;
        while ((o_busy || rx_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_idle_timeout: got busy after %0d cycles, need idle", name, n);
        end
        tick();
        tick();
        vectors++;
        if (tx_exp.size() != 0 || apb_exp.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d tx and %0d apb outstanding, need 0 and 0",
                     name, tx_exp.size(), apb_exp.size());
        end
    endtask

    task automatic test_reset();
        logic [OW-1:0] outs;
        #20;
        outs = {o_penable, o_pwrite, o_fifo_write, o_fifo_read, o_busy,
                o_fifo_wdata, o_paddr, o_pwdata};
        vectors++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, need 0", outs);
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        tick();
        vectors++;
        if (o_busy !== 1'b0 || o_penable !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b penable=%b, need 0 0", o_busy, o_penable);
        end
    endtask

    task automatic test_single_write();
        send_cmd(8'hA1, 8'h00, 32'h0000_1000);
        send_word(32'hDEAD_BEEF);
        exp_apb(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
        tx_exp.push_back(8'h00);
        wait_idle("single_write");
        vectors++;
        if (last_run != 1) begin
            errors++;
            $display("FAIL single_write_penable_len: got %0d, need 1", last_run);
        end
    endtask

    task automatic test_burst_read();
        prd_q.push_back(32'h11);
        prd_q.push_back(32'h22);
        prd_q.push_back(32'h33);
        send_cmd(8'hA2, 8'h02, 32'h0000_2000);
        for (int i = 0; i < 3; i++) begin
            exp_apb(1'b0, 32'h0000_2000 + 32'(4 * i), '0);
            exp_word(32'(8'h11 * (i + 1)));
        end
        tx_exp.push_back(8'h00);
        wait_idle("burst_read");
    endtask

    task automatic test_burst_write_fixed();
        send_cmd(8'hA1, 8'h01, 32'h0000_3000);
        send_word(32'h1);
        send_word(32'h2);
        exp_apb(1'b1, 32'h0000_3000, 32'h1);
        exp_apb(1'b1, 32'h0000_3000, 32'h2);
        tx_exp.push_back(8'h00);
        wait_idle("burst_write_fixed");
    endtask

    task automatic test_timeout();
        int runs0;
        i_pready = 1'b0;
        prd_q.push_back(32'hFFFF_FFFF);
        runs0 = pen_runs;
        send_cmd(8'hA0, 8'h00, 32'h0000_4000);
        exp_word(32'h0);
        tx_exp.push_back(8'h01);
        wait_idle("timeout");
        vectors++;
        if (last_run != 16 || pen_runs != runs0 + 1) begin
            errors++;
            $display("FAIL timeout_penable: got len %0d runs %0d, need len 16 runs 1",
                     last_run, pen_runs - runs0);
        end
        // Burst with timeout: second beat must skip the bus and return zeros.
        runs0 = pen_runs;
        send_cmd(8'hA2, 8'h01, 32'h0000_4100);
        exp_word(32'h0);
        exp_word(32'h0);
        tx_exp.push_back(8'h01);
        wait_idle("timeout_burst");
        vectors++;
        if (pen_runs != runs0 + 1) begin
            errors++;
            $display("FAIL timeout_burst_skip: got %0d penable runs, need 1", pen_runs - runs0);
        end
        prd_q.delete();
        i_pready = 1'b1;
        prd_q.push_back(32'h5A);
        send_cmd(8'hA0, 8'h00, 32'h0000_4000);
        exp_apb(1'b0, 32'h0000_4000, '0);
        exp_word(32'h5A);
        tx_exp.push_back(8'h00);
        wait_idle("after_timeout");
    endtask

    task automatic test_bad_op();
        rx_q.push_back(8'h55);
        tx_exp.push_back(8'hEE);
        prd_q.push_back(32'h77);
        send_cmd(8'hA0, 8'h00, 32'h0000_5000);
        exp_apb(1'b0, 32'h0000_5000, '0);
        exp_word(32'h77);
        tx_exp.push_back(8'h00);
        wait_idle("bad_op");
    endtask

    task automatic test_tx_stall();
        i_fifo_full = 1'b1;
        prd_q.push_back(32'hCAFE_F00D);
        send_cmd(8'hA0, 8'h00, 32'h0000_6000);
        exp_apb(1'b0, 32'h0000_6000, '0);
        exp_word(32'hCAFE_F00D);
        tx_exp.push_back(8'h00);
        for (int i = 0; i < 50; i++) tick();
        vectors++;
        if (tx_exp.size() != 5 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL tx_stall_hold: got %0d pending busy=%b, need 5 pending busy=1",
                     tx_exp.size(), o_busy);
        end
        i_fifo_full = 1'b0;
        wait_idle("tx_stall");
    endtask

    task automatic test_wrap_reset();
        logic [OW-1:0] outs;
        int n;
        prd_q.push_back(32'h1);
        prd_q.push_back(32'h2);
        send_cmd(8'hA2, 8'h01, 32'hFFFF_FFFC);
        exp_apb(1'b0, 32'hFFFF_FFFC, '0);
        exp_apb(1'b0, 32'h0000_0000, '0);
        exp_word(32'h1);
        exp_word(32'h2);
        tx_exp.push_back(8'h00);
        wait_idle("wrap");
        // Same burst again, reset asynchronously while the second beat is on the bus.
        prd_q.push_back(32'hA);
        prd_q.push_back(32'hB);
        send_cmd(8'hA2, 8'h01, 32'hFFFF_FFFC);
        exp_apb(1'b0, 32'hFFFF_FFFC, '0);
        exp_word(32'hA);
        n = 0;
        while (!(o_penable && o_paddr == '0) && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wrap_second_beat: got no access at 0 in %0d cycles, need one", n);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        outs = {o_penable, o_pwrite, o_fifo_write, o_fifo_read, o_busy,
                o_fifo_wdata, o_paddr, o_pwdata};
        vectors++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h, need 0", outs);
        end
        vectors++;
        if (tx_exp.size() != 0 || apb_exp.size() != 0) begin
            errors++;
            $display("FAIL pre_reset_drain: got %0d tx %0d apb outstanding, need 0 0",
                     tx_exp.size(), apb_exp.size());
        end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        prd_q.delete();
        pen_cur = 0;
        send_cmd(8'hA1, 8'h00, 32'h0000_7000);
        send_word(32'h1234_5678);
        exp_apb(1'b1, 32'h0000_7000, 32'h1234_5678);
        tx_exp.push_back(8'h00);
        wait_idle("post_reset");
    endtask

    initial begin
        i_rst_n     = 1'b1;
        i_fifo_full = 1'b0;
        i_pready    = 1'b1;
        refresh();
        #1;
        i_rst_n = 1'b0;
        test_reset();
        test_single_write();
        test_burst_read();
        test_burst_write_fixed();
        test_timeout();
        test_bad_op();
        test_tx_stall();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
